// File: rtl/conv_weight_loader.sv
// conv_weight_loader: fetches one 5x5 kernel plus bias from ROM and drives it as a weight_en burst
//
// Ports:
//   i_cnn_clk     clock, rising edge
//   i_cnn_rst     synchronous active-high reset
//   i_start       load request, honoured only in IDLE
//   i_kernel_idx  kernel to load, sampled with i_start
//   o_busy        high from accept until done (inclusive)
//   o_done        one-cycle pulse when the burst completes
//   o_err         one-cycle pulse when i_start carries an out-of-range kernel index
//   o_w_rom_addr  weight ROM read address
//   o_w_rom_rd    weight ROM read enable
//   i_w_rom_q     weight ROM data, valid one cycle after the read
//   o_b_rom_addr  bias ROM read address
//   o_b_rom_rd    bias ROM read enable
//   i_b_rom_q     bias ROM data, valid one cycle after the read
//   o_weight_en   burst qualifier to the conv2d consumer
//   o_weight      registered weight word (first beat of each burst is a zero pad)
//   o_bias        registered bias word, stable across the burst
module conv_weight_loader #(
    parameter int KERNEL_TAPS = 25,
    parameter int NUM_KERNELS = 6,
    parameter int W_ADDR_W    = 8,
    parameter int B_ADDR_W    = 3,
    parameter int DATA_W      = 16
) (
    input  logic                i_cnn_clk,
    input  logic                i_cnn_rst,
    input  logic                i_start,
    input  logic [2:0]          i_kernel_idx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [W_ADDR_W-1:0] o_w_rom_addr,
    output logic                o_w_rom_rd,
    input  logic [DATA_W-1:0]   i_w_rom_q,
    output logic [B_ADDR_W-1:0] o_b_rom_addr,
    output logic                o_b_rom_rd,
    input  logic [DATA_W-1:0]   i_b_rom_q,
    output logic                o_weight_en,
    output logic [DATA_W-1:0]   o_weight,
    output logic [DATA_W-1:0]   o_bias
);
    localparam int CNT_W = $clog2(KERNEL_TAPS + 2);

    typedef enum logic [2:0] {S_IDLE, S_BFETCH, S_WFETCH, S_LOAD, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W_ADDR_W-1:0] r_base;
    logic [B_ADDR_W-1:0] r_kidx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                r_weight_en;
    logic [DATA_W-1:0]   r_weight;
    logic [DATA_W-1:0]   r_bias;
    logic                w_idx_ok;
    logic                w_accept;
    logic                w_last;
    logic                w_latch;

    assign w_idx_ok = 32'(i_kernel_idx) < NUM_KERNELS;
    assign w_accept = r_state == S_IDLE && i_start && w_idx_ok;
    // r_cnt is 1 on the first LOAD cycle and reaches KERNEL_TAPS+1 on the final beat
    assign w_last   = r_state == S_LOAD && 32'(r_cnt) == KERNEL_TAPS + 1;
    // ROM data lags the address by one cycle, so LOAD cycles 1..KERNEL_TAPS capture words 0..KERNEL_TAPS-1
    assign w_latch  = r_state == S_LOAD && 32'(r_cnt) <= KERNEL_TAPS;

    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_state == S_DONE;
    assign o_err        = r_err;
    assign o_weight_en  = r_weight_en;
    assign o_weight     = r_weight;
    assign o_bias       = r_bias;
    assign o_b_rom_rd   = r_state == S_BFETCH;
    assign o_b_rom_addr = o_b_rom_rd ? r_kidx : '0;
    assign o_w_rom_rd   = (r_state == S_WFETCH || r_state == S_LOAD) && 32'(r_cnt) < KERNEL_TAPS;
    assign o_w_rom_addr = o_w_rom_rd ? r_base + W_ADDR_W'(r_cnt) : '0;

    always_ff @(posedge i_cnn_clk) begin
        if (i_cnn_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_BFETCH : S_IDLE;
            S_BFETCH: w_next = S_WFETCH;
            S_WFETCH: w_next = S_LOAD;
            S_LOAD:   w_next = w_last ? S_DONE : S_LOAD;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_cnn_clk) begin
        if (i_cnn_rst) begin
            r_base      <= '0;
            r_kidx      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_weight_en <= 1'b0;
            r_weight    <= '0;
            r_bias      <= '0;
        end else begin
            r_err <= r_state == S_IDLE && i_start && !w_idx_ok;
            if (w_accept) begin
                r_base <= W_ADDR_W'(i_kernel_idx) * W_ADDR_W'(KERNEL_TAPS);
                r_kidx <= B_ADDR_W'(i_kernel_idx);
            end
            r_cnt <= (r_state == S_WFETCH || r_state == S_LOAD) ? r_cnt + 1'b1 : '0;
            // WFETCH sets up the zero pad beat; bias data from the BFETCH read is valid now
            if (r_state == S_WFETCH) begin
                r_bias      <= i_b_rom_q;
                r_weight    <= '0;
                r_weight_en <= 1'b1;
            end
            if (w_latch)
                r_weight <= i_w_rom_q;
            if (w_last)
                r_weight_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader: scoreboard bench for conv_weight_loader with behavioural weight/bias ROMs
module tb_conv_weight_loader;
    typedef struct {
        int          cyc;
        logic [15:0] v;
        logic [15:0] b;
    } item_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  kidx;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  w_addr;
    logic        w_rd;
    logic [15:0] w_q;
    logic [2:0]  b_addr;
    logic        b_rd;
    logic [15:0] b_q;
    logic        weight_en;
    logic [15:0] weight;
    logic [15:0] bias;

    logic [15:0] wrom [256];
    logic [15:0] brom [8];
    logic [15:0] cons [25];
    int          caddr;
    logic        prev_en;
    logic        mon_en;
    int          cyc;
    int          n_chk;
    int          n_fail;

    item_t q_beat [$];
    item_t q_wa [$];
    item_t q_ba [$];
    int    q_done [$];
    int    q_err [$];
    int    q_kern [$];

    conv_weight_loader dut (
        .i_cnn_clk   (clk),
        .i_cnn_rst   (rst),
        .i_start     (start),
        .i_kernel_idx(kidx),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_w_rom_addr(w_addr),
        .o_w_rom_rd  (w_rd),
        .i_w_rom_q   (w_q),
        .o_b_rom_addr(b_addr),
        .o_b_rom_rd  (b_rd),
        .i_b_rom_q   (b_q),
        .o_weight_en (weight_en),
        .o_weight    (weight),
        .o_bias      (bias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        w_q <= w_rd ? wrom[w_addr] : 16'hDEAD;
        b_q <= b_rd ? brom[b_addr] : 16'hBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected output event (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            item_t e;
            int    x;
            int    idx;
            if (b_rd) begin
                if (q_ba.size() == 0) unexp("b_rom_rd");
                else begin
                    e = q_ba.pop_front();
                    chk("b_rd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("b_rom_addr", 32'(b_addr), 32'(e.v));
                end
            end
            if (w_rd) begin
                if (q_wa.size() == 0) unexp("w_rom_rd");
                else begin
                    e = q_wa.pop_front();
                    chk("w_rd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("w_rom_addr", 32'(w_addr), 32'(e.v));
                end
            end
            if (weight_en) begin
                if (q_beat.size() == 0) unexp("weight_en");
                else begin
                    e = q_beat.pop_front();
                    chk("beat_cycle", 32'(cyc), 32'(e.cyc));
                    chk("weight", 32'(weight), 32'(e.v));
                    chk("bias", 32'(bias), 32'(e.b));
                end
                idx = prev_en ? caddr : 0;
                if (idx > 0 && idx <= 25) cons[idx-1] <= weight;
                caddr <= idx + 1;
            end
            if (err) begin
                if (q_err.size() == 0) unexp("err");
                else chk("err_cycle", 32'(cyc), 32'(q_err.pop_front()));
            end
            if (done) begin
                if (q_done.size() == 0) unexp("done");
                else chk("done_cycle", 32'(cyc), 32'(q_done.pop_front()));
                if (q_kern.size() == 0) unexp("consumer");
                else begin
                    x = q_kern.pop_front();
                    chk("consumer_beats", 32'(caddr), 32'd26);
                    chk("consumer_bias", 32'(bias), 32'(brom[x]));
                    for (int i = 0; i < 25; i++)
                        chk("consumer_weight", 32'(cons[i]), 32'(16'h0100 + 16'(25 * x + i)));
                end
            end
            prev_en <= weight_en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_load(input int k, input int t, input int cut);
        item_t e;
        e.b = 16'h0380 + 16'(k * 16);
        if (cut >= 1) begin
            e.cyc = t + 1;
            e.v   = 16'(k);
            q_ba.push_back(e);
        end
        for (int j = 0; j < 25; j++)
            if (2 + j <= cut) begin
                e.cyc = t + 2 + j;
                e.v   = 16'(25 * k + j);
                q_wa.push_back(e);
            end
        for (int m = 0; m < 26; m++)
            if (3 + m <= cut) begin
                e.cyc = t + 3 + m;
                e.v   = m == 0 ? 16'h0000 : 16'h0100 + 16'(25 * k + m - 1);
                q_beat.push_back(e);
            end
        if (cut >= 29) begin
            q_done.push_back(t + 29);
            q_kern.push_back(k);
        end
    endtask

    task automatic issue(input int idx, input int cut, output int t);
        t     = cyc;
        start = 1'b1;
        kidx  = idx[2:0];
        if (idx >= 6) q_err.push_back(t + 1);
        else push_load(idx, t, cut);
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t2;
        for (int i = 0; i < 256; i++) wrom[i] = 16'h0100 + 16'(i);
        for (int i = 0; i < 8; i++) brom[i] = 16'h0380 + 16'(i * 16);
        cyc = 0;
        n_chk = 0;
        n_fail = 0;
        mon_en = 1'b0;
        prev_en = 1'b0;
        caddr = 0;
        rst = 1'b1;
        start = 1'b0;
        kidx = 3'd0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_weight_en", 32'(weight_en), 32'd0);
        chk("rst_weight", 32'(weight), 32'd0);
        chk("rst_bias", 32'(bias), 32'd0);
        chk("rst_w_rd", 32'(w_rd), 32'd0);
        chk("rst_b_rd", 32'(b_rd), 32'd0);
        mon_en = 1'b1;
        step();

        issue(0, 99, t);
        @(negedge clk);
        chk("t1_busy_start", 32'(busy), 32'd1);
        goto(t + 29);
        @(negedge clk);
        chk("t1_busy_done", 32'(busy), 32'd1);
        goto(t + 30);
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        goto(t + 32);

        issue(5, 99, t);
        goto(t + 32);

        issue(6, 99, t);
        @(negedge clk);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_weight_en", 32'(weight_en), 32'd0);
        goto(t + 3);
        issue(7, 99, t);
        @(negedge clk);
        chk("t3b_busy", 32'(busy), 32'd0);
        goto(t + 3);

        issue(1, 99, t);
        goto(t + 10);
        start = 1'b1;
        kidx  = 3'd3;
        step();
        start = 1'b0;
        goto(t + 29);
        start = 1'b1;
        kidx  = 3'd4;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("t4_busy_after", 32'(busy), 32'd0);
        goto(t + 35);

        issue(3, 15, t);
        goto(t + 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_weight_en", 32'(weight_en), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        goto(t + 18);
        issue(2, 99, t2);
        goto(t2 + 31);

        issue(4, 99, t);
        goto(t + 30);
        issue(0, 99, t2);
        goto(t2 + 32);

        chk("left_beats", 32'(q_beat.size()), 32'd0);
        chk("left_w_addr", 32'(q_wa.size()), 32'd0);
        chk("left_b_addr", 32'(q_ba.size()), 32'd0);
        chk("left_done", 32'(q_done.size()), 32'd0);
        chk("left_err", 32'(q_err.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
